// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the legal operand-width range.
package serial_arith_pkg;

  localparam int SERIAL_WIDTH_MIN = 2;
  localparam int SERIAL_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fsm_if.sv
// Request/result bundle between a controlling FSM (master) and the serial adder (slave).
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/fa_cell.sv
// Single-bit combinational full adder.
// Latency: none (pure combinational). No flow control.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder (A + B + cin), one bit per clock; SERIAL_ADDER_SUB_EN adds A - B mode.
// Latency: done pulses WIDTH+1 cycles after the accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module serial_adder_fsm
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_fsm_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < SERIAL_WIDTH_MIN || WIDTH > SERIAL_WIDTH_MAX) begin : g_width_check
    $error("serial_adder_fsm: WIDTH outside supported range");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    count;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] ld_b;
  logic             ld_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1: invert B and force the initial carry, ignoring cin.
  assign ld_b = bus.sub ? ~bus.b : bus.b;
  assign ld_c = bus.sub | bus.cin;
`else
  assign ld_b = bus.b;
  assign ld_c = bus.cin;
`endif

  fa_cell u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      count     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= ld_b;
            carry  <= ld_c;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= {fa_sum, res[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_cout;
          if (count == CW'(WIDTH - 1)) begin
            // Carry into the MSB, kept for the signed-overflow flag.
            carry_msb <= carry;
            busy_q    <= 1'b0;
            state     <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          sum_q  <= res;
          cout_q <= carry;
          ovf_q  <= carry_msb ^ carry;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder_fsm.md
# serial_adder_fsm

Parametrised bit-serial adder that computes WIDTH-bit A + B + cin using one full-adder cell and a carry flip-flop, one bit per clock. It is the sequential successor of the team's single-bit dataflow full adder. It trades latency for area in arithmetic datapaths, with a start/busy/done handshake towards the controlling FSM.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock, no other clock domains
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- sub  input  1  subtract mode; present only with SERIAL_ADDER_SUB_EN; captured with operands
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result; held until the next done
- cout  output  1  carry-out of the MSB; held with sum
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB); held with sum

## Operation
- States:
  - IDLE: waits for start; start=1 loads op_a, op_b, carry <= cin, count <= 0, then moves to SHIFT.
  - SHIFT: each cycle the full-adder cell adds op_a[0], op_b[0] and carry; the sum bit shifts into the result register at the MSB and op_a/op_b shift right. Carry updates, count increments; on count == WIDTH-1 the FSM moves to DONE.
  - DONE: the result register is copied to sum/cout/ovf, done=1, and the FSM returns to IDLE.
- ovf uses the carry register value before the final (MSB) step XOR the final carry.
- start is ignored in SHIFT and DONE, with no queuing; a new operation needs start high in IDLE.
- Operands may change freely after the accepting edge.
- Count register width is $clog2(WIDTH); there is no wrap beyond WIDTH-1.
- Reset mid-operation aborts immediately: state IDLE, partial result discarded, outputs cleared.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, internal registers 0.
- start sampled high at edge k:
  - busy=1 after edge k.
  - The last bit is computed at edge k+WIDTH.
  - done=1, busy=0 and valid outputs after edge k+WIDTH+1, so latency is WIDTH+1 cycles.
- done is high for exactly one cycle. The earliest next accepted start is at edge k+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists.
  - sub=1 computes A - B as A + ~B + 1: B is inverted bitwise at load, the carry is forced to 1, and cin is ignored.
  - cout=1 means no borrow; ovf is signed overflow of the subtraction.
  - sub=0 behaves as plain addition.
- SERIAL_ADDER_SUB_EN undefined: no sub port and addition only; the inverter and the forcing logic are absent.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, SHIFT, DONE) and its 2-bit encoding
  - the WIDTH min/max constants
- One sub-module, fa_cell: a combinational single-bit full adder (a, b, cin -> sum, cout). It is instantiated once inside serial_adder_fsm.
- Top level contains the FSM, the shift registers, the carry flip-flop, the bit counter and the output registers.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, one-cycle start -> busy for 8 cycles; done exactly 9 cycles after the start edge; sum=0x10, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Busy start: start re-pulsed at cycles 2 and 5 of an operation, with a/b changed to 0xAA/0x55 -> ignored; the original result is unchanged and only one done pulse occurs.
- Reset mid-operation: rst_n low asynchronously at cycle 4 -> busy=0 and sum=0 before the next edge; no done pulse. The following start with a=0x03, b=0x04 gives sum=0x07.
- SERIAL_ADDER_SUB_EN, sub=1:
  - a=0x05, b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0 (cin ignored).
  - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=2 exhaustive: all 32 combinations of a, b and cin -> {cout,sum} == a+b+cin, with done latency of 3 cycles each.
